// File: rtl/iris_argmax_classifier.sv
// Output stage for the Iris network.
// Latches the NUM_CLASSES signed neuron outputs on Start. It then scans them
// one per clock to find the largest, and publishes the winning index and
// value with a single-cycle Valid pulse. Ties resolve to the lowest index.
module iris_argmax_classifier #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 3,
  localparam int CLASS_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              En,
  input  logic                              Start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] Y_in,
  output logic [CLASS_W-1:0]                Class,
  output logic signed [DATA_WIDTH-1:0]      Max_Val,
  output logic                              Valid,
  output logic                              Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] yr [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best;
  logic [CLASS_W-1:0]           best_idx;
  logic [CLASS_W-1:0]           idx;
  logic                         last_idx;

  assign last_idx = (idx == CLASS_W'(NUM_CLASSES - 1));
  assign Busy     = (state_q != IDLE);

  // State register: reset wins, otherwise advance only on enabled edges.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      state_q <= IDLE;
    end else if (En) begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the capture / scan / publish sequence.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a case arm leaves state_d untouched.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = COMPARE;
      COMPARE: if (last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture inputs, run the running-max scan, publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the capture array is cleared explicitly. It is small, and
      // clearing it makes state after reset fully deterministic. Larger
      // memories would normally be left unreset.
      for (int k = 0; k < NUM_CLASSES; k++) begin
        yr[k] <= '0;
      end
      best     <= '0;
      best_idx <= '0;
      idx      <= '0;
      Class    <= '0;
      Max_Val  <= '0;
      Valid    <= 1'b0;
    end else if (En) begin
      Valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              yr[k] <= Y_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
            best     <= Y_in[DATA_WIDTH-1:0];
            best_idx <= '0;
            idx      <= CLASS_W'(1);
          end
        end
        COMPARE: begin
          // Strict greater-than: an equal later value never displaces the
          // earlier one, so ties go to the lowest index.
          if (yr[idx] > best) begin
            best     <= yr[idx];
            best_idx <= idx;
          end
          if (!last_idx) begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          Class   <= best_idx;
          Max_Val <= best;
          Valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
